cv32e40p_x_result_buf: RTL and testbench
========================================

Name: cv32e40p_x_result_buf

Overview:
- Result-side companion of the X-interface dispatcher. Accepts coprocessor results on the X result channel and buffers them in a small FIFO.
- Drains the FIFO into the spare write port of the integer register file whenever the core's own writeback does not occupy it.
- Reports each retired result (rd, we) to the dispatcher scoreboard, and exposes a pending-rd mask so the dispatcher can hold off dependent instructions.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- X_RFW_WIDTH, 32, result data width.
- X_ID_WIDTH, 4, offload ID width; matches the dispatcher ID counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- x_result_valid_i  in  1  coprocessor result valid.
- x_result_ready_o  out  1  buffer can accept a result.
- x_result_id_i  in  X_ID_WIDTH  offload ID of the result.
- x_result_data_i  in  X_RFW_WIDTH  result data.
- x_result_rd_i  in  5  destination register.
- x_result_we_i  in  1  result writes rd.
- core_we_wb_i  in  1  core WB stage uses the shared write port this cycle.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  X_RFW_WIDTH  register-file write data.
- retire_valid_o  out  1  one buffered result retired this cycle; drives the dispatcher result-valid input.
- retire_we_o  out  1  the retired entry had we set.
- retire_rd_o  out  5  rd of the retired entry.
- retire_id_o  out  X_ID_WIDTH  ID of the retired entry.
- rd_pending_o  out  32  bit r set when any valid entry has we=1 and rd=r.
- occupancy_o  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Pointers and count are cleared.
  - Every output is 0 except x_result_ready_o, which is 1.
  - Reset asserted mid-operation discards every buffered entry; no retire pulse is generated for discarded entries.
- Storage: circular FIFO with read and write pointers of width $clog2(DEPTH); pointers wrap naturally. A separate count tracks fill.
- Ready: x_result_ready_o = (count != DEPTH).
  - Depends on registered state only.
  - No pop-through: when the FIFO is full, no result is accepted in that cycle, even if a pop happens in the same cycle.
- Push: when x_result_valid_i & x_result_ready_o, store {id, data, rd, we} at the write pointer; the write pointer increments.
- Pop: when count != 0 and core_we_wb_i = 0, the head entry retires that cycle.
  - rf_we_o = head.we & (head.rd != 0). Writes to x0 are suppressed, but the entry still retires.
  - rf_waddr_o / rf_wdata_o = head fields; both are 0 when there is no pop.
  - retire_valid_o = 1; retire_we_o / retire_rd_o / retire_id_o = head fields, all 0 when retire_valid_o = 0.
  - The read pointer increments.
- Core priority: core_we_wb_i = 1 blocks any pop that cycle; the FIFO holds its state and can still accept a push.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Latency: a result accepted in cycle N is written in cycle N+1 at the earliest (FIFO empty, port free).
- Order: strict FIFO order. Results retire in acceptance order regardless of ID.
- rd_pending_o: combinational OR over valid entries. An entry that is popping in the current cycle still counts.
- occupancy_o = count.
- Assertions, under simulation only:
  - no push while full;
  - x_result_rd_i is known (not X) when x_result_valid_i = 1.

Optional Feature:
- Macro: CV32E40P_X_RESULT_BYPASS_EN.
- Defined: when the FIFO is empty, core_we_wb_i = 0 and x_result_valid_i = 1, the result is written and retired in the same cycle.
  - rf_* and retire_* outputs are driven directly from the x_result_* inputs; nothing is stored; latency is 0.
  - x_result_ready_o is unchanged.
  - rd_pending_o does not include the bypassed result.
- Undefined: no bypass; minimum latency 1 cycle as described above.

Decomposition:
- Shared package cv32e40p_core_v_xif_pkg gains:
  - typedef x_result_entry_t {id, data, rd, we};
  - constant X_RESULT_BUF_DEPTH = 2.
- One sub-module, cv32e40p_x_result_fifo: a generic DEPTH-entry FIFO of x_result_entry_t with push/pop, full/empty and count outputs.
- The top level holds the pop arbitration, x0 suppression, bypass logic and the pending-rd mask.

Test Plan:
- Reset then idle: x_result_ready_o=1, occupancy_o=0, rf_we_o=0, retire_valid_o=0, rd_pending_o=0.
- Single result {id=3, rd=5, we=1, data=0xDEADBEEF}, core_we_wb_i=0:
  - next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, retire_valid_o=1, retire_id_o=3;
  - rd_pending_o[5]=1 only in that cycle.
- core_we_wb_i held 1 while 3 results arrive (DEPTH=2):
  - ready drops after 2 pushes, third held, occupancy_o=2;
  - release core_we_wb_i → retires in order rd 1, 2, then third accepted and retired.
- Result with rd=0, we=1: rf_we_o=0, retire_valid_o=1, retire_we_o=1, retire_rd_o=0.
- Result with we=0, rd=7: rf_we_o=0, retire_valid_o=1, retire_we_o=0, rd_pending_o[7]=0 throughout.
- Assert rst_i with 2 entries buffered: occupancy_o=0 and ready=1 immediately; no retire pulse before or after release. With CV32E40P_X_RESULT_BYPASS_EN defined, an empty-FIFO result writes in the same cycle.

Source files
------------

// File: rtl/cv32e40p_core_v_xif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_core_v_xif_pkg
// Description : Shared X-interface types and constants, including the result
//               buffer entry layout and its default depth.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_RESULT_BUF_DEPTH = 2;
  localparam int unsigned X_RESULT_ID_WIDTH  = 4;
  localparam int unsigned X_RESULT_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_RESULT_ID_WIDTH-1:0]  id;
    logic [X_RESULT_RFW_WIDTH-1:0] data;
    logic [4:0]                    rd;
    logic                          we;
  } x_result_entry_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_x_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_x_result_fifo
// Description : Generic DEPTH-entry circular FIFO (power-of-two depth) that
//               also exposes every slot and its valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_x_result_fifo
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH   = X_RESULT_BUF_DEPTH,
  parameter type         ENTRY_T = x_result_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  ENTRY_T                     push_data_i,
  input  logic                       pop_i,
  output ENTRY_T                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output ENTRY_T                     entries_o [DEPTH],
  output logic [DEPTH-1:0]           valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] w_off;
    assign w_off        = PTR_W'(i) - r_rptr;
    assign valid_o[i]   = (CNT_W'(w_off) < r_count);
    assign entries_o[i] = r_mem[i];
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
`endif

endmodule
`default_nettype wire

// File: rtl/cv32e40p_x_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_x_result_buf
// Description : Buffers X-interface coprocessor results and drains them into
//               the spare register-file write port when the core leaves it
//               free. CV32E40P_X_RESULT_BYPASS_EN enables a zero-latency path
//               when the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_x_result_buf
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH       = X_RESULT_BUF_DEPTH,
  parameter int unsigned X_RFW_WIDTH = 32,
  parameter int unsigned X_ID_WIDTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_result_valid_i,
  output logic                       x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]      x_result_id_i,
  input  logic [X_RFW_WIDTH-1:0]     x_result_data_i,
  input  logic [4:0]                 x_result_rd_i,
  input  logic                       x_result_we_i,
  input  logic                       core_we_wb_i,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [X_RFW_WIDTH-1:0]     rf_wdata_o,
  output logic                       retire_valid_o,
  output logic                       retire_we_o,
  output logic [4:0]                 retire_rd_o,
  output logic [X_ID_WIDTH-1:0]      retire_id_o,
  output logic [31:0]                rd_pending_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
  } entry_t;

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  entry_t           w_in;
  entry_t           w_head;
  entry_t           w_ret;
  entry_t           w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic             w_ret_valid;

  assign w_in = '{id: x_result_id_i, data: x_result_data_i, rd: x_result_rd_i, we: x_result_we_i};

  // Ready looks at registered fill only, so a full buffer never accepts even while popping.
  assign x_result_ready_o = ~w_full;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
  assign w_bypass = w_empty & ~core_we_wb_i & x_result_valid_i & ~rst_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = x_result_valid_i & x_result_ready_o & ~w_bypass;
  assign w_pop  = ~w_empty & ~core_we_wb_i;

  cv32e40p_x_result_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_in),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count),
    .entries_o   (w_entries),
    .valid_o     (w_valid)
  );

  always_comb begin
    w_ret_valid = w_pop | w_bypass;
    w_ret       = '0;
    if (w_pop)         w_ret = w_head;
    else if (w_bypass) w_ret = w_in;
  end

  // x0 writes are dropped at the port but still retire to the scoreboard.
  assign rf_we_o        = w_ret_valid & w_ret.we & (w_ret.rd != 5'd0);
  assign rf_waddr_o     = w_ret.rd;
  assign rf_wdata_o     = w_ret.data;
  assign retire_valid_o = w_ret_valid;
  assign retire_we_o    = w_ret.we;
  assign retire_rd_o    = w_ret.rd;
  assign retire_id_o    = w_ret.id;
  assign occupancy_o    = w_count;

  always_comb begin
    rd_pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && w_entries[i].we) rd_pending_o[w_entries[i].rd] = 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_rd_known: assert property (@(posedge clk_i) disable iff (rst_i)
    x_result_valid_i |-> !$isunknown(x_result_rd_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_x_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_x_result_buf
// Description : Directed self-checking bench for the X result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_x_result_buf;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        x_result_valid_i = 1'b0;
  logic        x_result_ready_o;
  logic [3:0]  x_result_id_i = '0;
  logic [31:0] x_result_data_i = '0;
  logic [4:0]  x_result_rd_i = '0;
  logic        x_result_we_i = 1'b0;
  logic        core_we_wb_i = 1'b0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        retire_valid_o;
  logic        retire_we_o;
  logic [4:0]  retire_rd_o;
  logic [3:0]  retire_id_o;
  logic [31:0] rd_pending_o;
  logic [1:0]  occupancy_o;

  int errors = 0;
  int checks = 0;

  cv32e40p_x_result_buf #(
    .DEPTH       (2),
    .X_RFW_WIDTH (32),
    .X_ID_WIDTH  (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_id_i    (x_result_id_i),
    .x_result_data_i  (x_result_data_i),
    .x_result_rd_i    (x_result_rd_i),
    .x_result_we_i    (x_result_we_i),
    .core_we_wb_i     (core_we_wb_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .retire_valid_o   (retire_valid_o),
    .retire_we_o      (retire_we_o),
    .retire_rd_o      (retire_rd_o),
    .retire_id_o      (retire_id_o),
    .rd_pending_o     (rd_pending_o),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one cycle of inputs on the falling edge and settle before checking.
  task automatic drive(input logic v, input logic [3:0] id, input logic [31:0] data,
                       input logic [4:0] rd, input logic we, input logic core);
    @(negedge clk_i);
    x_result_valid_i = v;
    x_result_id_i    = id;
    x_result_data_i  = data;
    x_result_rd_i    = rd;
    x_result_we_i    = we;
    core_we_wb_i     = core;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (x_result_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h want 1", x_result_ready_o); end
    checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0h want 0", rf_we_o); end
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL reset_retire_valid: got %0h want 0", retire_valid_o); end
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL reset_rd_pending: got %0h want 0", rd_pending_o); end
  endtask

  task automatic test_single();
    drive(1'b1, 4'd3, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
`ifdef CV32E40P_X_RESULT_BYPASS_EN
    checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL byp_rf_we: got %0h want 1", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd5) begin errors++; $display("FAIL byp_waddr: got %0d want 5", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_wdata: got %0h want deadbeef", rf_wdata_o); end
    checks++; if (retire_id_o !== 4'd3) begin errors++; $display("FAIL byp_id: got %0d want 3", retire_id_o); end
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL byp_rd_pending: got %0h want 0", rd_pending_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL byp_after_valid: got %0h want 0", retire_valid_o); end
    checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL byp_after_occ: got %0d want 0", occupancy_o); end
`else
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL single_early_we: got %0h want 0", rf_we_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL single_rf_we: got %0h want 1", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd5) begin errors++; $display("FAIL single_waddr: got %0d want 5", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata: got %0h want deadbeef", rf_wdata_o); end
    checks++; if (retire_valid_o !== 1'b1) begin errors++; $display("FAIL single_retire_valid: got %0h want 1", retire_valid_o); end
    checks++; if (retire_id_o !== 4'd3) begin errors++; $display("FAIL single_retire_id: got %0d want 3", retire_id_o); end
    checks++; if (rd_pending_o !== 32'h20) begin errors++; $display("FAIL single_rd_pending: got %0h want 20", rd_pending_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL single_rd_pending_clr: got %0h want 0", rd_pending_o); end
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL single_retire_clr: got %0h want 0", retire_valid_o); end
`endif
  endtask

  task automatic test_core_block();
    drive(1'b1, 4'd1, 32'h11, 5'd1, 1'b1, 1'b1);
    checks++; if (x_result_ready_o !== 1'b1) begin errors++; $display("FAIL blk_ready0: got %0h want 1", x_result_ready_o); end
    drive(1'b1, 4'd2, 32'h22, 5'd2, 1'b1, 1'b1);
    checks++; if (occupancy_o !== 2'd1) begin errors++; $display("FAIL blk_occ1: got %0d want 1", occupancy_o); end
    checks++; if (rd_pending_o !== 32'h2) begin errors++; $display("FAIL blk_pend1: got %0h want 2", rd_pending_o); end
    drive(1'b1, 4'd3, 32'h33, 5'd3, 1'b1, 1'b1);
    checks++; if (x_result_ready_o !== 1'b0) begin errors++; $display("FAIL blk_ready_full: got %0h want 0", x_result_ready_o); end
    checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL blk_occ2: got %0d want 2", occupancy_o); end
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL blk_no_retire: got %0h want 0", retire_valid_o); end
    checks++; if (rd_pending_o !== 32'h6) begin errors++; $display("FAIL blk_pend2: got %0h want 6", rd_pending_o); end
    drive(1'b1, 4'd3, 32'h33, 5'd3, 1'b1, 1'b0);
    checks++; if (x_result_ready_o !== 1'b0) begin errors++; $display("FAIL blk_no_popthrough: got %0h want 0", x_result_ready_o); end
    checks++; if (retire_rd_o !== 5'd1) begin errors++; $display("FAIL blk_ret1_rd: got %0d want 1", retire_rd_o); end
    checks++; if (rf_wdata_o !== 32'h11) begin errors++; $display("FAIL blk_ret1_data: got %0h want 11", rf_wdata_o); end
    drive(1'b1, 4'd3, 32'h33, 5'd3, 1'b1, 1'b0);
    checks++; if (x_result_ready_o !== 1'b1) begin errors++; $display("FAIL blk_ready_again: got %0h want 1", x_result_ready_o); end
    checks++; if (retire_rd_o !== 5'd2 || retire_id_o !== 4'd2) begin errors++; $display("FAIL blk_ret2: got rd=%0d id=%0d want rd=2 id=2", retire_rd_o, retire_id_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (retire_valid_o !== 1'b1 || retire_rd_o !== 5'd3) begin errors++; $display("FAIL blk_ret3: got valid=%0h rd=%0d want valid=1 rd=3", retire_valid_o, retire_rd_o); end
    checks++; if (occupancy_o !== 2'd1) begin errors++; $display("FAIL blk_occ_last: got %0d want 1", occupancy_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL blk_occ_empty: got %0d want 0", occupancy_o); end
  endtask

  task automatic test_x0();
    drive(1'b1, 4'd4, 32'hCAFE, 5'd0, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_rf_we: got %0h want 0", rf_we_o); end
    checks++; if (retire_valid_o !== 1'b1) begin errors++; $display("FAIL x0_retire_valid: got %0h want 1", retire_valid_o); end
    checks++; if (retire_we_o !== 1'b1) begin errors++; $display("FAIL x0_retire_we: got %0h want 1", retire_we_o); end
    checks++; if (retire_rd_o !== 5'd0 || retire_id_o !== 4'd4) begin errors++; $display("FAIL x0_retire_fields: got rd=%0d id=%0d want rd=0 id=4", retire_rd_o, retire_id_o); end
    checks++; if (rd_pending_o !== 32'h1) begin errors++; $display("FAIL x0_rd_pending: got %0h want 1", rd_pending_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_we0();
    drive(1'b1, 4'd5, 32'h1234, 5'd7, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    checks++; if (occupancy_o !== 2'd1) begin errors++; $display("FAIL we0_occ: got %0d want 1", occupancy_o); end
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL we0_pend_held: got %0h want 0", rd_pending_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL we0_rf_we: got %0h want 0", rf_we_o); end
    checks++; if (retire_valid_o !== 1'b1) begin errors++; $display("FAIL we0_retire_valid: got %0h want 1", retire_valid_o); end
    checks++; if (retire_we_o !== 1'b0 || retire_rd_o !== 5'd7) begin errors++; $display("FAIL we0_retire_fields: got we=%0h rd=%0d want we=0 rd=7", retire_we_o, retire_rd_o); end
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL we0_pend_pop: got %0h want 0", rd_pending_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd8, 32'hA1, 5'd11, 1'b1, 1'b0);
`ifdef CV32E40P_X_RESULT_BYPASS_EN
    checks++; if (retire_valid_o !== 1'b1 || retire_rd_o !== 5'd11) begin errors++; $display("FAIL b2b_c1: got valid=%0h rd=%0d want valid=1 rd=11", retire_valid_o, retire_rd_o); end
    drive(1'b1, 4'd9, 32'hA2, 5'd12, 1'b1, 1'b0);
    checks++; if (retire_rd_o !== 5'd12 || occupancy_o !== 2'd0) begin errors++; $display("FAIL b2b_c2: got rd=%0d occ=%0d want rd=12 occ=0", retire_rd_o, occupancy_o); end
    drive(1'b1, 4'd10, 32'hA3, 5'd13, 1'b1, 1'b0);
    checks++; if (rf_wdata_o !== 32'hA3 || occupancy_o !== 2'd0) begin errors++; $display("FAIL b2b_c3: got data=%0h occ=%0d want data=a3 occ=0", rf_wdata_o, occupancy_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_c4: got valid=%0h want 0", retire_valid_o); end
`else
    checks++; if (retire_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL b2b_c1: got valid=%0h occ=%0d want valid=0 occ=0", retire_valid_o, occupancy_o); end
    drive(1'b1, 4'd9, 32'hA2, 5'd12, 1'b1, 1'b0);
    checks++; if (retire_rd_o !== 5'd11 || occupancy_o !== 2'd1) begin errors++; $display("FAIL b2b_c2: got rd=%0d occ=%0d want rd=11 occ=1", retire_rd_o, occupancy_o); end
    drive(1'b1, 4'd10, 32'hA3, 5'd13, 1'b1, 1'b0);
    checks++; if (retire_rd_o !== 5'd12 || occupancy_o !== 2'd1) begin errors++; $display("FAIL b2b_c3: got rd=%0d occ=%0d want rd=12 occ=1", retire_rd_o, occupancy_o); end
    checks++; if (rd_pending_o !== 32'h1000) begin errors++; $display("FAIL b2b_pend: got %0h want 1000", rd_pending_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (retire_rd_o !== 5'd13 || retire_id_o !== 4'd10 || rf_wdata_o !== 32'hA3) begin errors++; $display("FAIL b2b_c4: got rd=%0d id=%0d data=%0h want rd=13 id=10 data=a3", retire_rd_o, retire_id_o, rf_wdata_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (occupancy_o !== 2'd0 || retire_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_c5: got occ=%0d valid=%0h want occ=0 valid=0", occupancy_o, retire_valid_o); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd6, 32'h66, 5'd9, 1'b1, 1'b1);
    drive(1'b1, 4'd7, 32'h77, 5'd10, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL rstm_occ_pre: got %0d want 2", occupancy_o); end
    checks++; if (rd_pending_o !== 32'h600) begin errors++; $display("FAIL rstm_pend_pre: got %0h want 600", rd_pending_o); end
    @(negedge clk_i);
    rst_i        = 1'b1;
    core_we_wb_i = 1'b0;
    #1;
    checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL rstm_occ: got %0d want 0", occupancy_o); end
    checks++; if (x_result_ready_o !== 1'b1) begin errors++; $display("FAIL rstm_ready: got %0h want 1", x_result_ready_o); end
    checks++; if (retire_valid_o !== 1'b0 || rf_we_o !== 1'b0) begin errors++; $display("FAIL rstm_no_retire: got valid=%0h we=%0h want 0 0", retire_valid_o, rf_we_o); end
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL rstm_pend: got %0h want 0", rd_pending_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (retire_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL rstm_release: got valid=%0h occ=%0d want 0 0", retire_valid_o, occupancy_o); end
    drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL rstm_after: got valid=%0h want 0", retire_valid_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_core_block();
    test_x0();
    test_we0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
